pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 6, meaning the number of pipeline stages and the width of the stall vector.
REQ-002 SHALL have parameter NREQ, default 4, meaning the number of stall requesters.
REQ-003 SHALL have parameter LVL_W, default 3, meaning the width of one requester level field; the range is 2^LVL_W >= STAGES.
REQ-004 SHALL have parameter FLUSH_CYC, default 2, meaning the number of cycles the flush pulse lasts; the range is 1..15.
REQ-005 SHALL have parameter TMO_CYC, default 1024, meaning the count of consecutive stall cycles before timeout.
REQ-006 SHALL have parameter CNT_W, default 32, meaning the width of the performance counters.
REQ-007 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port stall_req, input, NREQ bits: one stall request per requester.
REQ-010 SHALL have port req_level, input, NREQ*LVL_W bits: per requester, the deepest stage index to freeze. Requester i occupies bits [i*LVL_W +: LVL_W].
REQ-011 SHALL have port flush_req, input, 1 bit: exception/redirect request, single-cycle pulse.
REQ-012 SHALL have port stall, output, STAGES bits: per-stage hold; bit 0 is the PC stage.
REQ-013 SHALL have port flush, output, 1 bit: clear all pipeline registers.
REQ-014 SHALL have port busy, output, 1 bit: state is not RUN.
REQ-015 SHALL have port stall_tmo, output, 1 bit: sticky timeout flag.
REQ-016 SHALL have port stall_cycles, output, CNT_W bits: number of cycles with stall != 0.
REQ-017 SHALL have port flush_count, output, CNT_W bits: number of accepted flushes.

Function
REQ-018 SHALL compute L = max(req_level[i]) over all i with stall_req[i]=1. Values of L >= STAGES SHALL clamp to STAGES-1.
REQ-019 SHALL drive stall[k]=1 for k<=L and stall[k]=0 for k>L, combinationally in the same cycle. With no request active, stall SHALL be 0.
REQ-020 SHALL implement FSM states RUN, STALL and FLUSH, updated on the clk rising edge.
REQ-021 SHALL make the following transitions:
- RUN->STALL when any stall_req is active and flush_req=0.
- STALL->RUN when no stall_req is active.
- Any state->FLUSH when flush_req=1.
- FLUSH->RUN after FLUSH_CYC cycles.
REQ-022 SHALL, in FLUSH, drive flush=1 and stall=0, with all stall_req ignored. The flush output SHALL be registered: it asserts the cycle after flush_req and lasts exactly FLUSH_CYC cycles.
REQ-023 SHALL, when flush_req and stall_req are active simultaneously, give flush priority. The combinational stall output in that cycle SHALL still follow REQ-019.
REQ-024 SHALL, when flush_req arrives during FLUSH, reload the flush counter so that FLUSH lasts FLUSH_CYC more cycles.
REQ-025 SHALL drive busy=1 whenever the state is STALL or FLUSH.
REQ-026 SHALL increment a consecutive-stall counter on each cycle the state is STALL. The counter SHALL clear on entry to RUN or FLUSH.
REQ-027 SHALL set stall_tmo when the consecutive-stall counter reaches TMO_CYC. stall_tmo SHALL remain set until reset or an accepted flush, and SHALL NOT alter the stall output.
REQ-028 SHALL saturate the consecutive-stall counter at TMO_CYC; it SHALL NOT wrap.

Reset
REQ-029 SHALL, while rst=0, immediately force: state RUN, flush=0, busy=0, stall_tmo=0, all counters 0.
REQ-030 SHALL, while rst=0, force stall to 0 regardless of stall_req.
REQ-031 SHALL, on reset asserted mid-FLUSH or mid-STALL, abandon the operation. After release, operation SHALL resume in RUN with no residual flush pulse.

Configuration
REQ-032 SHALL, with macro PIPE_CTRL_PERF_EN defined, implement stall_cycles and flush_count. Both SHALL increment by 1 on the qualifying cycle or event and wrap modulo 2^CNT_W.
REQ-033 SHALL, without PIPE_CTRL_PERF_EN, tie stall_cycles and flush_count to 0 and instantiate no counter flops. All other behaviour SHALL be unchanged.

Verification
REQ-034 SHALL cover level decode: with defaults, stall_req=4'b0011 and levels {r0=2, r1=3} -> stall=6'b001111 in the same cycle; remove both requests -> stall=0 and state RUN next cycle.
REQ-035 SHALL cover clamping: req_level=7 with STAGES=6 -> stall=6'b111111.
REQ-036 SHALL cover flush priority: flush_req and stall_req pulsed together -> flush=1 for exactly 2 cycles, stall=0 during FLUSH, busy=1 for 2 cycles, then RUN.
REQ-037 SHALL cover timeout: with TMO_CYC=8, hold stall_req for 8 cycles -> stall_tmo=1 on cycle 8, held through removal of stall_req; a subsequent flush_req -> stall_tmo=0.
REQ-038 SHALL cover reset mid-flush: rst=0 during the first FLUSH cycle -> flush=0 immediately; after release, state RUN and counters 0.
REQ-039 SHALL cover performance counters (PERF_EN): 5 stall cycles and 2 flushes -> stall_cycles=5 and flush_count=2; without the macro, both read 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: level-based stall mask, registered flush pulse, stall timeout.
// Optional performance counters are enabled with macro PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int STAGES    = 6,
    parameter int NREQ      = 4,
    parameter int LVL_W     = 3,
    parameter int FLUSH_CYC = 2,
    parameter int TMO_CYC   = 1024,
    parameter int CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        stall_req,
    input  logic [NREQ*LVL_W-1:0]  req_level,
    input  logic                   flush_req,
    output logic [STAGES-1:0]      stall,
    output logic                   flush,
    output logic                   busy,
    output logic                   stall_tmo,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic [CNT_W-1:0]       flush_count
);

    localparam int TW = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        fcnt;
    logic [TW-1:0]     scnt;
    logic              tmo_hit;
    logic [LVL_W-1:0]  lvl;
    logic              any_req;
    logic [STAGES-1:0] mask;

    // Deepest requested stage among active requesters, clamped to the last stage.
    always_comb begin
        lvl     = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (stall_req[i]) begin
                any_req = 1'b1;
                if (req_level[i*LVL_W +: LVL_W] > lvl)
                    lvl = req_level[i*LVL_W +: LVL_W];
            end
        end
        if (32'(lvl) >= 32'(STAGES))
            lvl = LVL_W'(STAGES - 1);
        mask = '0;
        for (int unsigned k = 0; k < STAGES; k++)
            mask[k] = any_req && (32'(lvl) >= k);
    end

    // Mask is combinational; reset and FLUSH both force it low.
    assign stall = (rst && (state != FLUSH)) ? mask : '0;
    assign flush = (state == FLUSH);
    assign busy  = (state != RUN);

    always_comb begin
        state_nx = state;
        if (flush_req) begin
            state_nx = FLUSH;
        end else begin
            case (state)
                RUN:     if (any_req) state_nx = STALL;
                STALL:   if (!any_req) state_nx = RUN;
                FLUSH:   if (fcnt == 4'd0) state_nx = RUN;
                default: state_nx = RUN;
            endcase
        end
    end

    assign tmo_hit = (state == STALL) && (state_nx == STALL) && (scnt == TW'(TMO_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            fcnt      <= '0;
            scnt      <= '0;
            stall_tmo <= 1'b0;
        end else begin
            state <= state_nx;

            if (flush_req)
                fcnt <= 4'(FLUSH_CYC - 1);
            else if ((state == FLUSH) && (fcnt != 4'd0))
                fcnt <= fcnt - 4'd1;

            // Consecutive-stall count clears on any exit from STALL and saturates at TMO_CYC.
            if (state_nx != STALL)
                scnt <= '0;
            else if ((state == STALL) && (scnt != TW'(TMO_CYC)))
                scnt <= scnt + TW'(1);

            if (flush_req)
                stall_tmo <= 1'b0;
            else if (tmo_hit)
                stall_tmo <= 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] sc_q;
    logic [CNT_W-1:0] fc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc_q <= '0;
            fc_q <= '0;
        end else begin
            if (|stall)
                sc_q <= sc_q + CNT_W'(1);
            if (flush_req)
                fc_q <= fc_q + CNT_W'(1);
        end
    end

    assign stall_cycles = sc_q;
    assign flush_count  = fc_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
